cache_mem_arbiter: RTL

Shares the single main-memory/L2 port between the I-cache controller (read-only) and the D-cache controller (read/write).
- Grants exactly one requester at a time.
- Latches the granted command, address and write data, and holds them on the memory port until memory responds.
- Routes the response back to the granted requester only.
- Uses D-priority arbitration, with a bounded D burst so the I-cache cannot starve.

---
 rtl/cache_mem_arb_pkg.sv | 30 +++
 rtl/cache_mem_arbiter_if.sv | 47 ++++
 rtl/cache_mem_arb_picker.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cache_mem_arb_pkg.sv
// Shared types and defaults for the I/D cache memory-port arbiter.
// The arbiter FSM states, the picker's grant encoding and the streak counter width live here.
package cache_mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    // Wide enough for the largest legal burst bound (15).
    localparam int STREAK_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    function automatic logic [STREAK_W-1:0] sat_inc(
        input logic [STREAK_W-1:0] value,
        input logic [STREAK_W-1:0] limit
    );
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the environment driving requests and memory.
interface cache_mem_arbiter_if
    import cache_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);

    logic              i_mem_r;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;

    logic              d_mem_r;
    logic              d_mem_w;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;

    logic              mem_r;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_mem_r, i_mem_addr,
        input  d_mem_r, d_mem_w, d_mem_addr, d_mem_wdata,
        input  mem_rdata, mem_resp,
        output i_mem_rdata, i_mem_resp,
        output d_mem_rdata, d_mem_resp,
        output mem_r, mem_w, mem_addr, mem_wdata
    );

    modport master (
        output i_mem_r, i_mem_addr,
        output d_mem_r, d_mem_w, d_mem_addr, d_mem_wdata,
        output mem_rdata, mem_resp,
        input  i_mem_rdata, i_mem_resp,
        input  d_mem_rdata, d_mem_resp,
        input  mem_r, mem_w, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_mem_arb_picker.sv
// Pure arbitration policy: D-priority with a bounded run of contested D grants.
// Returns the winner and the streak value to store if this decision is taken.
module cache_mem_arb_picker
    import cache_mem_arb_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic [STREAK_W-1:0] d_streak_i,
    output grant_t              grant_o,
    output logic [STREAK_W-1:0] d_streak_next_o
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_BURST);

    logic i_forced;

    // I only gets forced in once D has won MAX_D_BURST contested rounds in a row.
    assign i_forced = i_req_i && (d_streak_i >= MAX_STREAK);

    always_comb begin
        grant_o         = GNT_NONE;
        d_streak_next_o = d_streak_i;
        if (d_req_i && !i_forced) begin
            grant_o         = GNT_D;
            d_streak_next_o = i_req_i ? sat_inc(d_streak_i, MAX_STREAK) : '0;
        end else if (i_req_i) begin
            grant_o         = GNT_I;
            d_streak_next_o = '0;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory/L2 port between the I-cache (reads) and D-cache (reads and write-backs).
// The winning command is latched and held until memory answers; the answer goes only to the winner.
module cache_mem_arbiter
    import cache_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int MAX_D_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_mem_arbiter_if.slave  bus,
    output arb_state_t          state_o,
    output logic [STREAK_W-1:0] d_streak_o
);

    arb_state_t          state_q,     state_d;
    logic [STREAK_W-1:0] d_streak_q,  d_streak_d;
    logic                mem_r_q,     mem_r_d;
    logic                mem_w_q,     mem_w_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

    grant_t              grant;
    logic [STREAK_W-1:0] d_streak_nxt;
    logic                d_req;
    logic                i_resp;
    logic                d_resp;

    assign d_req = bus.d_mem_r | bus.d_mem_w;

    cache_mem_arb_picker #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_picker (
        .i_req_i         (bus.i_mem_r),
        .d_req_i         (d_req),
        .d_streak_i      (d_streak_q),
        .grant_o         (grant),
        .d_streak_next_o (d_streak_nxt)
    );

    always_comb begin
        state_d     = state_q;
        d_streak_d  = d_streak_q;
        mem_r_d     = mem_r_q;
        mem_w_d     = mem_w_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_resp      = 1'b0;
        d_resp      = 1'b0;

        case (state_q)
            IDLE: begin
                d_streak_d = d_streak_nxt;
                case (grant)
                    GNT_I: begin
                        state_d     = GRANT_I;
                        mem_r_d     = 1'b1;
                        mem_w_d     = 1'b0;
                        mem_addr_d  = bus.i_mem_addr;
                        mem_wdata_d = '0;
                    end
                    GNT_D: begin
                        // A write-back takes precedence if the D side raises both.
                        state_d     = GRANT_D;
                        mem_r_d     = ~bus.d_mem_w;
                        mem_w_d     = bus.d_mem_w;
                        mem_addr_d  = bus.d_mem_addr;
                        mem_wdata_d = bus.d_mem_wdata;
                    end
                    default: ;
                endcase
            end
            GRANT_I: begin
                if (bus.mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = RELEASE;
                    mem_r_d = 1'b0;
                    mem_w_d = 1'b0;
                end
            end
            GRANT_D: begin
                if (bus.mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = RELEASE;
                    mem_r_d = 1'b0;
                    mem_w_d = 1'b0;
                end
            end
            RELEASE: begin
                // Turnaround cycle lets the finished requester drop its level request.
                state_d = IDLE;
                mem_r_d = 1'b0;
                mem_w_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                mem_r_d = 1'b0;
                mem_w_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_streak_q  <= '0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            d_streak_q  <= d_streak_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.mem_r       = mem_r_q;
    assign bus.mem_w       = mem_w_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

    // Read data is a plain mirror; only the matching resp qualifies it.
    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;
    assign bus.i_mem_resp  = i_resp;
    assign bus.d_mem_resp  = d_resp;

    assign state_o    = state_q;
    assign d_streak_o = d_streak_q;

endmodule
